// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives one active-low column at a time, samples synchronized rows,
// and debounces whole-scan results into a level-style key_pressed / key_value pair.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 27000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_pressed,
  output logic [3:0] key_value
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

  // Hex code printed on the key at row r, column c.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic          acc_hit, scan_hit, scan_vld;
  logic [3:0]    acc_key, scan_key;
  logic          sample;
  logic [1:0]    row_idx;
  logic          cur_hit;
  logic [3:0]    cur_key;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic          kp_d;
  logic [3:0]    kv_d;

  // Two-flop synchronizer; idle rows read high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  assign sample = (dwell == DWELL_LAST);

  // Lowest pressed row in the current column wins.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) row_idx = 2'(i);
    end
  end

  // Earlier columns already holding a hit keep priority over this column.
  always_comb begin
    cur_hit = (row_sync != 4'hF);
    cur_key = key_map(row_idx, col);
    if (col != 2'd0 && acc_hit) begin
      cur_hit = 1'b1;
      cur_key = acc_key;
    end
  end

  // Column dwell/advance and per-scan result accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell    <= '0;
      col      <= 2'd0;
      col_out  <= 4'b1110;
      acc_hit  <= 1'b0;
      acc_key  <= 4'h0;
      scan_hit <= 1'b0;
      scan_key <= 4'h0;
      scan_vld <= 1'b0;
    end else begin
      scan_vld <= sample && (col == 2'd3);
      if (sample) begin
        dwell   <= '0;
        col     <= col + 2'd1;
        col_out <= ~(4'b0001 << (col + 2'd1));
        if (col == 2'd3) begin
          scan_hit <= cur_hit;
          scan_key <= cur_key;
        end else begin
          acc_hit <= cur_hit;
          acc_key <= cur_key;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Debounce FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_pressed <= 1'b0;
      key_value   <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_pressed <= kp_d;
      key_value   <= kv_d;
    end
  end

  // Evaluated once per completed scan.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    kp_d    = key_pressed;
    kv_d    = key_value;
    if (scan_vld) begin
      case (state_q)
        IDLE: begin
          if (scan_hit) begin
            state_d = DEB_PRESS;
            cand_d  = scan_key;
            cnt_d   = CW'(1);
          end
        end
        DEB_PRESS: begin
          if (!scan_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (scan_key != cand_q) begin
            cand_d = scan_key;
            cnt_d  = CW'(1);
          end else if (cnt_q + CW'(1) == CNT_DONE) begin
            state_d = PRESSED;
            cnt_d   = '0;
            kp_d    = 1'b1;
            kv_d    = cand_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!scan_hit) begin
            state_d = DEB_REL;
            cnt_d   = CW'(1);
          end
        end
        default: begin
          if (scan_hit) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == CNT_DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
            kp_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner: an emulated key matrix, expected press/release
// events with latency windows queued by the stimulus, and a monitor that checks every output edge.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int SCAN    = 4 * SCAN_DIV;
  localparam int LAT_MIN = (DEB - 1) * SCAN;
  localparam int LAT_MAX = (DEB + 1) * SCAN + 3;
  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct {
    bit         rise;
    logic [3:0] key;
    int         lo;
    int         hi;
  } exp_t;

  logic       clk, rst;
  logic [3:0] row_in, col_out, key_value;
  logic       key_pressed;
  logic [15:0] mask;   // bit r*4+c = key at row r, column c is closed

  int   checks = 0, failures = 0;
  int   cyc = 0, k_since = 0;
  exp_t q[$];
  exp_t e;
  logic prev_kp = 1'b0;
  logic [3:0] prev_kv = 4'h0, exp_col;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_pressed(key_pressed), .key_value(key_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst) k_since <= !rst ? 0 : k_since + 1;

  // Passive matrix: a row is pulled low when a closed key connects it to the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(mask[r*4 +: 4] & ~col_out);
  end

  // Key the scanner should report: lowest column first, then lowest row.
  function automatic logic [4:0] prio(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[r*4 + c]) return {1'b1, KMAP[r*4 + c]};
    return 5'd0;
  endfunction

  task automatic push_evt(input bit rise, input logic [3:0] key, input int lo, input int hi);
    exp_t x;
    x.rise = rise; x.key = key; x.lo = lo; x.hi = hi;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [15:0] m);
    logic [4:0] p;
    p = prio(m);
    mask = m;
    push_evt(1'b1, p[3:0], cyc + LAT_MIN, cyc + LAT_MAX);
  endtask

  task automatic release_all();
    mask = 16'h0;
    push_evt(1'b0, 4'h0, cyc + LAT_MIN, cyc + LAT_MAX);
  endtask

  // Monitor: column walk, scoreboard of key_pressed edges, key_value stability.
  always @(negedge clk) begin
    if (!rst) begin
      prev_kp = 1'b0;
      prev_kv = 4'h0;
    end else begin
      exp_col = ~(4'(1) << ((k_since / SCAN_DIV) % 4));
      checks++;
      if (col_out !== exp_col) begin
        failures++;
        $display("FAIL col_walk cyc=%0d got=%b want=%b", cyc, col_out, exp_col);
      end
      if (key_pressed !== prev_kp) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_edge cyc=%0d key_pressed=%b", cyc, key_pressed);
        end else begin
          e = q.pop_front();
          if (e.rise != key_pressed || cyc < e.lo || cyc > e.hi ||
              (e.rise && key_value !== e.key)) begin
            failures++;
            $display("FAIL edge cyc=%0d got kp=%b kv=%h want kp=%b kv=%h window=[%0d,%0d]",
                     cyc, key_pressed, key_value, e.rise, e.key, e.lo, e.hi);
          end
        end
      end else if (q.size() > 0 && cyc > q[0].hi) begin
        checks++;
        failures++;
        $display("FAIL edge_timeout cyc=%0d got kp=%b want kp=%b by %0d",
                 cyc, key_pressed, q[0].rise, q[0].hi);
        void'(q.pop_front());
      end
      if (!(key_pressed && !prev_kp)) begin
        checks++;
        if (key_value !== prev_kv) begin
          failures++;
          $display("FAIL kv_stable cyc=%0d got=%h want=%h", cyc, key_value, prev_kv);
        end
      end
      prev_kp = key_pressed;
      prev_kv = key_value;
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (col_out !== 4'b1110 || key_pressed !== 1'b0 || key_value !== 4'h0) begin
      failures++;
      $display("FAIL %s got col=%b kp=%b kv=%h want col=1110 kp=0 kv=0",
               tag, col_out, key_pressed, key_value);
    end
  endtask

  initial begin
    rst  = 1'b0;
    mask = 16'h0;
    wait_cyc(3);
    check_reset_outputs("reset_state");
    rst = 1'b1;

    // Idle column walk with no key.
    wait_cyc(40);

    // Clean '7' (row 2, column 0).
    press(16'h1 << 8);
    wait_cyc(100);
    release_all();
    wait_cyc(80);

    // Bouncing '5' (row 1, column 1): no assertion may precede the settle point.
    push_evt(1'b1, 4'h5, cyc + 42, cyc + 42 + LAT_MAX);
    for (int i = 0; i < 14; i++) begin
      mask = (i % 2 == 0) ? (16'h1 << 5) : 16'h0;
      wait_cyc(3);
    end
    mask = 16'h1 << 5;
    wait_cyc(90);
    release_all();
    wait_cyc(80);

    // 'B' and '4' together: column 0 wins.
    press((16'h1 << 7) | (16'h1 << 4));
    wait_cyc(90);
    release_all();
    wait_cyc(80);

    // '#' held, then '1' added (ignored), release both, then '1' alone.
    press(16'h1 << 14);
    wait_cyc(80);
    mask = mask | 16'h1;
    wait_cyc(60);
    release_all();
    wait_cyc(80);
    press(16'h1);
    wait_cyc(80);
    release_all();
    wait_cyc(80);

    // Random single and double presses.
    for (int n = 0; n < 10; n++) begin
      logic [15:0] m;
      m = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) m = m | (16'h1 << $urandom_range(0, 15));
      press(m);
      wait_cyc(70 + int'($urandom_range(0, 60)));
      release_all();
      wait_cyc(70 + int'($urandom_range(0, 40)));
    end

    // Async reset while '9' is held, then re-debounce from scratch.
    press(16'h1 << 10);
    wait_cyc(80);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    q.delete();
    wait_cyc(3);
    rst = 1'b1;
    push_evt(1'b1, 4'h9, cyc + LAT_MIN, cyc + LAT_MAX);
    wait_cyc(90);
    release_all();
    wait_cyc(80);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
